// File: rtl/ro_puf_sequencer.sv
// Sequences one RO-PUF response: per challenge bit, steer both RO muxes,
// reset and race the two post-mux counters, and record which one won.
module ro_puf_sequencer #(
  parameter int unsigned N_BITS      = 8,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 2**24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [N_BITS*2*SEL_W-1:0] challenge,
  output logic [SEL_W-1:0]          mux_sel_a,
  output logic [SEL_W-1:0]          mux_sel_b,
  output logic                      cnt_reset,
  output logic                      cnt_enable,
  input  logic [CNT_W-1:0]          cnt_a,
  input  logic [CNT_W-1:0]          cnt_b,
  input  logic                      fin_a,
  input  logic                      fin_b,
  output logic                      busy,
  output logic                      done,
  output logic [N_BITS-1:0]         response,
  output logic                      timeout
);

  localparam int unsigned IdxW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned CycMax = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CycW   = $clog2(CycMax + 1);
  localparam int unsigned ChW    = N_BITS * 2 * SEL_W;

  localparam logic [IdxW-1:0] LastIdx     = IdxW'(N_BITS - 1);
  localparam logic [CycW-1:0] SettleLast  = CycW'(SETTLE_CYC - 1);
  localparam logic [CycW-1:0] TimeoutLast = CycW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSettle, StCount, StStop, StCompare, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [ChW-1:0]    chal_q, chal_d;
  logic [CNT_W-1:0]  snap_a_q, snap_a_d;
  logic [CNT_W-1:0]  snap_b_q, snap_b_d;
  logic [N_BITS-1:0] resp_q, resp_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cyc_q     <= '0;
      chal_q    <= '0;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cyc_q     <= cyc_d;
      chal_q    <= chal_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    chal_d     = chal_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    resp_d     = resp_q;
    timeout_d  = timeout_q;
    cnt_reset  = 1'b0;
    cnt_enable = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy      = 1'b0;
        cnt_reset = 1'b1;
        if (start) begin
          state_d   = StLoad;
          chal_d    = challenge;
          idx_d     = '0;
          resp_d    = '0;
          timeout_d = 1'b0;
        end
      end
      StLoad: begin
        cnt_reset = 1'b1;
        cyc_d     = '0;
        state_d   = StSettle;
      end
      StSettle: begin
        if (cyc_q == SettleLast) begin
          cyc_d   = '0;
          state_d = StCount;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StCount: begin
        cnt_enable = 1'b1;
        if (fin_a || fin_b) begin
          snap_a_d = cnt_a;
          snap_b_d = cnt_b;
          state_d  = StStop;
        end else if (cyc_q == TimeoutLast) begin
          // Zeroed snapshots make the compare yield a 0 bit for an aborted race.
          snap_a_d  = '0;
          snap_b_d  = '0;
          timeout_d = 1'b1;
          state_d   = StCompare;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StStop: state_d = StCompare;
      StCompare: begin
        resp_d[idx_q] = (snap_a_q > snap_b_q);
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StLoad;
        end
      end
      StDone: begin
        busy      = 1'b0;
        done      = 1'b1;
        cnt_reset = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Selects are only driven while a bit is in flight, so they never move under enable.
  logic        sel_active;
  int unsigned sel_base;

  always_comb begin
    sel_active = (state_q inside {StLoad, StSettle, StCount, StStop, StCompare});
    sel_base   = 32'(idx_q) * 2 * SEL_W;
    mux_sel_a  = '0;
    mux_sel_b  = '0;
    if (sel_active) begin
      mux_sel_a = chal_q[sel_base +: SEL_W];
      mux_sel_b = chal_q[sel_base + SEL_W +: SEL_W];
    end
  end

  assign response = resp_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer: drives the counter-side inputs by hand
// and checks every state's outputs cycle by cycle.
module tb_ro_puf_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] challenge;
  logic [3:0]  mux_sel_a, mux_sel_b;
  logic        cnt_reset, cnt_enable;
  logic [7:0]  cnt_a, cnt_b;
  logic        fin_a, fin_b;
  logic        busy, done;
  logic [3:0]  response;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  ro_puf_sequencer #(
    .N_BITS(4), .SEL_W(4), .CNT_W(8), .SETTLE_CYC(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .challenge(challenge),
    .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
    .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .fin_a(fin_a), .fin_b(fin_b),
    .busy(busy), .done(done), .response(response), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [31:0] ch);
    start = 1'b1;
    challenge = ch;
    @(negedge clk);
    start = 1'b0;
    challenge = ~ch;  // latched copy must be used from here on
  endtask

  task automatic check_load(input int i, input logic [31:0] ch);
    check("load_sel_a", mux_sel_a, ch[i*8 +: 4]);
    check("load_sel_b", mux_sel_b, ch[i*8+4 +: 4]);
    check("load_rst", cnt_reset, 1'b1);
    check("load_en", cnt_enable, 1'b0);
    check("load_busy", busy, 1'b1);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check("settle_rst", cnt_reset, 1'b0);
      check("settle_en", cnt_enable, 1'b0);
      fin_a = (s == 0);
      fin_b = (s == 0);
      @(negedge clk);
    end
    fin_a = 1'b0;
    fin_b = 1'b0;
  endtask

  // Starts at the LOAD-cycle negedge, ends at the negedge after COMPARE.
  task automatic do_bit(input int i, input logic [31:0] ch, input int wc, input logic fa,
                        input logic fb, input logic [7:0] ca, input logic [7:0] cb,
                        input bit poke);
    start = poke;
    check_load(i, ch);
    start = 1'b0;
    for (int w = 0; w < wc; w++) begin
      check("count_en", cnt_enable, 1'b1);
      @(negedge clk);
    end
    check("count_en", cnt_enable, 1'b1);
    check("count_sel_a", mux_sel_a, ch[i*8 +: 4]);
    fin_a = fa;
    fin_b = fb;
    cnt_a = ca;
    cnt_b = cb;
    @(negedge clk);
    check("stop_en", cnt_enable, 1'b0);
    fin_a = 1'b0;
    fin_b = 1'b0;
    cnt_a = cb;
    cnt_b = ca;
    @(negedge clk);
    check("cmp_en", cnt_enable, 1'b0);
    check("cmp_sel_b", mux_sel_b, ch[i*8+4 +: 4]);
    check("cmp_busy", busy, 1'b1);
    @(negedge clk);
  endtask

  task automatic do_bit_timeout(input int i, input logic [31:0] ch);
    check_load(i, ch);
    for (int w = 0; w < 16; w++) begin
      check("to_count_en", cnt_enable, 1'b1);
      @(negedge clk);
    end
    check("to_cmp_en", cnt_enable, 1'b0);
    check("to_cmp_flag", timeout, 1'b1);
    @(negedge clk);
  endtask

  task automatic finish_run(input logic [3:0] exp_resp, input logic exp_to, input int exp_dones,
                            input bit poke);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check("done_rst", cnt_reset, 1'b1);
    check("done_resp", response, exp_resp);
    check("done_timeout", timeout, exp_to);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("done_count", done_cnt, exp_dones);
    @(negedge clk);
    check("idle_busy2", busy, 1'b0);
    check("idle_resp_hold", response, exp_resp);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    challenge = '0;
    fin_a = 1'b0;
    fin_b = 1'b0;
    cnt_a = '0;
    cnt_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_resp", response, 4'h0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_cnt_rst", cnt_reset, 1'b1);
    check("rst_en", cnt_enable, 1'b0);
    check("rst_sel_a", mux_sel_a, 4'h0);
    check("rst_sel_b", mux_sel_b, 4'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", busy, 1'b0);

    // A always wins.
    start_run(32'h8765_4321);
    do_bit(0, 32'h8765_4321, 2, 1, 0, 8'h90, 8'h80, 0);
    do_bit(1, 32'h8765_4321, 0, 1, 0, 8'h80, 8'h7F, 0);
    do_bit(2, 32'h8765_4321, 5, 1, 0, 8'hC0, 8'h01, 0);
    do_bit(3, 32'h8765_4321, 1, 1, 0, 8'h81, 8'h80, 0);
    finish_run(4'hF, 1'b0, 1, 0);

    // Alternating winner; start pokes during settle and in DONE are dropped.
    start_run(32'h1F2E_3D4C);
    do_bit(0, 32'h1F2E_3D4C, 1, 1, 0, 8'h80, 8'h70, 0);
    do_bit(1, 32'h1F2E_3D4C, 3, 0, 1, 8'h60, 8'h80, 1);
    do_bit(2, 32'h1F2E_3D4C, 0, 1, 0, 8'h90, 8'h10, 1);
    do_bit(3, 32'h1F2E_3D4C, 5, 0, 1, 8'h20, 8'h80, 0);
    finish_run(4'b0101, 1'b0, 2, 1);

    // Simultaneous finishes: equal gives 0, A one ahead gives 1.
    start_run(32'hA5A5_5A5A);
    do_bit(0, 32'hA5A5_5A5A, 2, 1, 1, 8'h40, 8'h40, 0);
    do_bit(1, 32'hA5A5_5A5A, 2, 1, 1, 8'h41, 8'h40, 0);
    do_bit(2, 32'hA5A5_5A5A, 4, 1, 1, 8'h7F, 8'h7F, 0);
    do_bit(3, 32'hA5A5_5A5A, 1, 1, 1, 8'h80, 8'h7F, 0);
    finish_run(4'b1010, 1'b0, 3, 0);

    // No finish ever: every bit aborts.
    start_run(32'h0123_4567);
    for (int i = 0; i < 4; i++) do_bit_timeout(i, 32'h0123_4567);
    finish_run(4'h0, 1'b1, 4, 0);

    // Timeout clears on accept; then reset during COUNT of bit 2.
    start_run(32'hCAFE_F00D);
    check("to_cleared", timeout, 1'b0);
    do_bit(0, 32'hCAFE_F00D, 1, 1, 0, 8'h50, 8'h40, 0);
    do_bit(1, 32'hCAFE_F00D, 1, 1, 0, 8'h50, 8'h40, 0);
    check_load(2, 32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    check("pre_rst_en", cnt_enable, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_en", cnt_enable, 1'b0);
    check("midrst_rst", cnt_reset, 1'b1);
    check("midrst_done", done, 1'b0);
    check("midrst_resp", response, 4'h0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, 4);
    check("midrst_idle", busy, 1'b0);

    // Fresh run restarts from bit 0.
    start_run(32'h8765_4321);
    do_bit(0, 32'h8765_4321, 3, 0, 1, 8'h10, 8'h20, 0);
    do_bit(1, 32'h8765_4321, 2, 1, 0, 8'h33, 8'h22, 0);
    do_bit(2, 32'h8765_4321, 1, 0, 1, 8'h05, 8'h05, 0);
    do_bit(3, 32'h8765_4321, 0, 1, 0, 8'hFF, 8'hFE, 0);
    finish_run(4'b1010, 1'b0, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
